// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R). The arbiter uses the slave view toward
// each requester and the master view toward the memory port.
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between the icache (m0, bursts)
// and the LSU (m1, single beats); one transaction in flight, grant held to the last beat.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    axi_rd_arbiter_if.slave   m0,
    axi_rd_arbiter_if.slave   m1,
    axi_rd_arbiter_if.master  s
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]        state;
    logic              sel;
    logic              last;
    logic [8:0]        cnt;
    logic [7:0]        len;

    logic              sel_arvalid;
    logic [ADDR_W-1:0] sel_araddr;
    logic [2:0]        sel_arsize;
    logic [7:0]        sel_arlen;
    logic              sel_rready;
    logic [DATA_W-1:0] beat_data;
    logic              ar_hs;
    logic              r_beat;
    logic              r_end;

    // The LSU only ever issues single beats, so its burst length is forced to zero.
    assign sel_arvalid = sel ? m1.arvalid : m0.arvalid;
    assign sel_araddr  = sel ? m1.araddr  : m0.araddr;
    assign sel_arsize  = sel ? m1.arsize  : m0.arsize;
    assign sel_arlen   = sel ? 8'd0       : m0.arlen;
    assign sel_rready  = sel ? m1.rready  : m0.rready;
    assign beat_data   = s.rvalid ? s.rdata : '0;

    assign ar_hs  = (state == ADDR) & sel_arvalid & s.arready;
    assign r_beat = (state == DATA) & s.rvalid & sel_rready;
    // Stop on rlast, or after len+1 beats if the slave never flags the last one.
    assign r_end  = r_beat & (s.rlast | (cnt == {1'b0, len}));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
            cnt   <= 9'd0;
            len   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.arvalid | m1.arvalid) begin
                        sel   <= (m0.arvalid & m1.arvalid) ? ~last : m1.arvalid;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        len   <= sel_arlen;
                        cnt   <= 9'd0;
                        state <= DATA;
                    end else if (!sel_arvalid) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (r_beat) begin
                        cnt <= cnt + 9'd1;
                        if (r_end) begin
                            last  <= sel;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the state-dependent overrides,
    // so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        s.arvalid  = 1'b0;
        s.araddr   = '0;
        s.arlen    = 8'd0;
        s.arsize   = 3'd0;
        s.arburst  = 2'b01;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m0.rdata   = '0;
        m0.rlast   = 1'b0;
        m1.arready = 1'b0;
        m1.rvalid  = 1'b0;
        m1.rdata   = '0;
        m1.rlast   = 1'b0;

        if (state == ADDR) begin
            s.arvalid  = sel_arvalid;
            s.araddr   = sel_araddr;
            s.arlen    = sel_arlen;
            s.arsize   = sel_arsize;
            m0.arready = ~sel & sel_arvalid & s.arready;
            m1.arready =  sel & sel_arvalid & s.arready;
        end

        // Stray beats outside DATA are never acknowledged nor forwarded.
        if (state == DATA) begin
            s.rready = sel_rready;
            if (!sel) begin
                m0.rvalid = s.rvalid;
                m0.rdata  = beat_data;
                m0.rlast  = s.rlast;
            end else begin
                m1.rvalid = s.rvalid;
                m1.rdata  = beat_data;
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: requester and memory agents plus a
// transaction-level reference of round-robin grant, routing and beat counting.
module tb_axi_rd_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
    axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Requester agents
    bit          pend     [2];
    logic [31:0] req_addr [2];
    logic [7:0]  req_len  [2];
    logic [2:0]  req_size [2];
    bit          rx_on    [2];
    logic [31:0] rx_addr  [2];
    int          rx_len   [2];
    int          rx_beat  [2];
    int          done_cnt [2];
    int          issued   [2];
    int          ar_pulse [2];
    bit          rr       [2];

    // Memory agent
    bit          sl_busy;
    logic [31:0] sl_addr;
    int          sl_len;
    int          sl_beat;
    bit          sl_norlast;
    bit          sa_ready;
    bit          sr_valid;
    bit          sr_last;
    logic [31:0] sr_data;

    // Knobs (percent)
    int req_pct [2];
    int ar_pct      = 100;
    int rv_pct      = 100;
    int rr_pct      = 100;
    int stray_pct   = 0;
    int norlast_pct = 0;
    bit rst_req     = 1'b1;
    bit post_rst    = 1'b0;

    // Reference: who is granted / who owns the data phase
    int owner     = -1;
    int granted   = -1;
    int grant_cyc = 0;
    int own_len   = 0;
    int own_beats = 0;
    int last_srv  = 1;
    int cyc       = 0;
    int grant_log [$];

    function automatic logic [31:0] bus_word(input logic [31:0] a, input int b);
        return a ^ 32'h5A5A_0000 ^ (32'(b) << 24) ^ 32'(b);
    endfunction

    function automatic bit tb_busy();
        return pend[0] || pend[1] || rx_on[0] || rx_on[1] || sl_busy || owner >= 0 || granted >= 0;
    endfunction

    task automatic new_req(input int x, input logic [31:0] addr, input logic [7:0] blen);
        pend[x]     = 1'b1;
        req_addr[x] = addr;
        req_len[x]  = (x == 0) ? blen : 8'd0;
        req_size[x] = 3'($urandom_range(2));
        issued[x]++;
    endtask

    task automatic step();
        logic exp_arv, exp_ar0, exp_ar1, exp_rr, exp_rv0, exp_rv1;
        bit   addr_ph;
        @(negedge clock);
        if (rst_req) begin
            pend[0] = 1'b0; pend[1] = 1'b0;
            rx_on[0] = 1'b0; rx_on[1] = 1'b0;
            sl_busy = 1'b0;
        end else begin
            for (int x = 0; x < 2; x++)
                if (!pend[x] && $urandom_range(99) < req_pct[x])
                    new_req(x, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(15)));
        end

        reset = rst_req;
        for (int x = 0; x < 2; x++) rr[x] = $urandom_range(99) < rr_pct;
        m0_bus.arvalid = pend[0]; m0_bus.araddr = req_addr[0]; m0_bus.arlen = req_len[0];
        m0_bus.arsize  = req_size[0]; m0_bus.arburst = 2'b01; m0_bus.rready = rr[0];
        m1_bus.arvalid = pend[1]; m1_bus.araddr = req_addr[1]; m1_bus.arlen = 8'($urandom);
        m1_bus.arsize  = req_size[1]; m1_bus.arburst = 2'b01; m1_bus.rready = rr[1];
        sa_ready = $urandom_range(99) < ar_pct;
        if (sl_busy) begin
            sr_valid = $urandom_range(99) < rv_pct;
            sr_data  = bus_word(sl_addr, sl_beat);
            sr_last  = (sl_beat == sl_len) && !sl_norlast;
        end else begin
            sr_valid = $urandom_range(99) < stray_pct;
            sr_data  = $urandom;
            sr_last  = 1'($urandom_range(1));
        end
        s_bus.arready = sa_ready; s_bus.rvalid = sr_valid;
        s_bus.rdata   = sr_data;  s_bus.rlast  = sr_last;
        #1;

        if (rst_req) begin
            owner = -1; granted = -1; last_srv = 1; post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                check("post_rst_araddr", s_bus.araddr, 0);
                check("post_rst_arlen", s_bus.arlen, 0);
                check("post_rst_arsize", s_bus.arsize, 0);
                post_rst = 1'b0;
            end
            // Waiting requests are arbitrated once nothing is in flight; a tie goes to
            // the master not served last, and the address phase opens one cycle later.
            if (owner < 0 && granted < 0 && (pend[0] || pend[1])) begin
                granted   = (pend[0] && pend[1]) ? 1 - last_srv : (pend[1] ? 1 : 0);
                grant_cyc = cyc + 1;
            end
            addr_ph = granted >= 0 && cyc >= grant_cyc;
            exp_arv = addr_ph && pend[granted];
            exp_ar0 = exp_arv && granted == 0 && sa_ready;
            exp_ar1 = exp_arv && granted == 1 && sa_ready;
            exp_rr  = owner >= 0 && rr[owner];
            exp_rv0 = owner == 0 && sr_valid;
            exp_rv1 = owner == 1 && sr_valid;
            check("handshake_ctl",
                  {s_bus.arvalid, m0_bus.arready, m1_bus.arready, s_bus.rready, m0_bus.rvalid, m1_bus.rvalid},
                  {exp_arv, exp_ar0, exp_ar1, exp_rr, exp_rv0, exp_rv1});
            if (exp_arv) begin
                check("s_araddr", s_bus.araddr, req_addr[granted]);
                check("s_arlen", s_bus.arlen, (granted == 0) ? req_len[0] : 8'd0);
                check("s_arsize", s_bus.arsize, req_size[granted]);
                check("s_arburst", s_bus.arburst, 2'b01);
            end
            check("m0_rdata_route", m0_bus.rdata, exp_rv0 ? sr_data : 32'd0);
            check("m1_rdata_route", m1_bus.rdata, exp_rv1 ? sr_data : 32'd0);

            // Requester view: own handshakes and beat contents
            if (m0_bus.rvalid && rr[0]) begin
                check("m0_beat_expected", m0_bus.rvalid, rx_on[0]);
                if (rx_on[0]) begin
                    check("m0_beat_data", m0_bus.rdata, bus_word(rx_addr[0], rx_beat[0]));
                    check("m0_rlast", m0_bus.rlast, (rx_beat[0] == rx_len[0]) && !sl_norlast);
                    rx_beat[0]++;
                    if (rx_beat[0] > rx_len[0]) begin rx_on[0] = 1'b0; done_cnt[0]++; end
                end
            end
            if (m1_bus.rvalid && rr[1]) begin
                check("m1_beat_expected", m1_bus.rvalid, rx_on[1]);
                if (rx_on[1]) begin
                    check("m1_beat_data", m1_bus.rdata, bus_word(rx_addr[1], 0));
                    rx_on[1] = 1'b0; done_cnt[1]++;
                end
            end
            if (m0_bus.arready && pend[0]) begin
                ar_pulse[0]++; pend[0] = 1'b0; rx_on[0] = 1'b1;
                rx_addr[0] = req_addr[0]; rx_len[0] = req_len[0]; rx_beat[0] = 0;
            end
            if (m1_bus.arready && pend[1]) begin
                ar_pulse[1]++; pend[1] = 1'b0; rx_on[1] = 1'b1;
                rx_addr[1] = req_addr[1]; rx_len[1] = 0; rx_beat[1] = 0;
            end

            // Memory view
            if (sl_busy && sr_valid && s_bus.rready) begin
                sl_beat++;
                if (sl_beat > sl_len) sl_busy = 1'b0;
            end
            if (s_bus.arvalid && sa_ready) begin
                sl_busy = 1'b1; sl_addr = s_bus.araddr; sl_len = int'(s_bus.arlen); sl_beat = 0;
                sl_norlast = $urandom_range(99) < norlast_pct;
            end

            // Reference bookkeeping
            if (owner >= 0 && sr_valid && rr[owner]) begin
                own_beats++;
                if (sr_last || own_beats == own_len + 1) begin last_srv = owner; owner = -1; end
            end
            if (exp_arv && sa_ready) begin
                grant_log.push_back(granted);
                owner = granted; own_len = (granted == 0) ? int'(req_len[0]) : 0; own_beats = 0;
                granted = -1;
            end else if (addr_ph && !pend[granted]) begin
                granted = -1;
            end
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        for (n = 0; n < budget && tb_busy(); n++) step();
        check("drain_done", tb_busy(), 1'b0);
    endtask

    task automatic wait_m0_beats(input int nb, input int budget);
        int n;
        for (n = 0; n < budget && !(rx_on[0] && rx_beat[0] >= nb); n++) step();
        check("m0_beats_reached", rx_on[0] && rx_beat[0] >= nb, 1'b1);
    endtask

    task automatic do_reset();
        rst_req = 1'b1; step(); rst_req = 1'b0;
    endtask

    initial begin
        int base, d0, d1, i0, i1;
        req_pct[0] = 0; req_pct[1] = 0;
        do_reset(); do_reset();
        step();

        // Lone icache burst
        d0 = done_cnt[0];
        new_req(0, 32'h8000_0010, 8'd3);
        drain(200);
        check("t1_m0_done", done_cnt[0] - d0, 1);
        check("t1_m1_idle", ar_pulse[1], 0);

        // Tie-breaking sequence right after reset
        do_reset();
        base = grant_log.size();
        new_req(0, 32'h0000_1000, 8'd1); new_req(1, 32'h0000_2000, 8'd0); drain(200);
        new_req(0, 32'h0000_3000, 8'd2); new_req(1, 32'h0000_4000, 8'd0); drain(200);
        new_req(0, 32'h0000_5000, 8'd0); drain(200);
        new_req(0, 32'h0000_6000, 8'd1); new_req(1, 32'h0000_7000, 8'd0); drain(200);
        check("rr_grant0", grant_log[base + 0], 0);
        check("rr_grant1", grant_log[base + 1], 1);
        check("rr_grant2", grant_log[base + 2], 0);
        check("rr_grant3", grant_log[base + 3], 1);
        check("rr_grant4", grant_log[base + 4], 0);
        check("rr_grant5", grant_log[base + 5], 1);
        check("rr_grant6", grant_log[base + 6], 0);

        // LSU request arriving mid-burst waits for the burst to finish
        base = grant_log.size(); d1 = done_cnt[1];
        new_req(0, 32'h8000_0040, 8'd3);
        wait_m0_beats(2, 100);
        new_req(1, 32'h8000_0100, 8'd0);
        drain(200);
        check("mid_grant_m0", grant_log[base], 0);
        check("mid_grant_m1", grant_log[base + 1], 1);
        check("mid_m1_done", done_cnt[1] - d1, 1);

        // Address phase stalled by the memory port
        i0 = ar_pulse[0];
        ar_pct = 0;
        new_req(0, 32'h8000_0200, 8'd1);
        repeat (4) step();
        ar_pct = 100;
        drain(200);
        check("stall_arready_pulses", ar_pulse[0] - i0, 1);

        // Memory never flags rlast: the beat count closes the burst
        base = grant_log.size(); d1 = done_cnt[1];
        norlast_pct = 100;
        new_req(0, 32'h8000_0300, 8'd3);
        step(); step();
        new_req(1, 32'h8000_0400, 8'd0);
        drain(200);
        norlast_pct = 0;
        check("norlast_next_m1", grant_log[base + 1], 1);
        check("norlast_m1_done", done_cnt[1] - d1, 1);

        // Requester withdraws before the address is accepted
        d1 = done_cnt[1];
        ar_pct = 0;
        new_req(0, 32'h8000_0500, 8'd0);
        step(); step();
        pend[0] = 1'b0; issued[0]--;
        step();
        ar_pct = 100;
        new_req(1, 32'h8000_0600, 8'd0);
        drain(200);
        check("withdraw_m1_done", done_cnt[1] - d1, 1);

        // Reset in the middle of a burst
        d0 = done_cnt[0]; d1 = done_cnt[1];
        new_req(0, 32'h8000_0700, 8'd3);
        wait_m0_beats(2, 100);
        issued[0]--;
        do_reset();
        step();
        new_req(1, 32'h8000_0800, 8'd0);
        drain(200);
        check("rst_m0_abandoned", done_cnt[0] - d0, 0);
        check("rst_m1_done", done_cnt[1] - d1, 1);

        // Random traffic with backpressure, stray beats and missing rlast
        d0 = done_cnt[0]; d1 = done_cnt[1]; i0 = issued[0]; i1 = issued[1];
        req_pct[0] = 30; req_pct[1] = 30;
        ar_pct = 60; rv_pct = 70; rr_pct = 70; stray_pct = 20; norlast_pct = 15;
        repeat (4000) step();
        req_pct[0] = 0; req_pct[1] = 0;
        drain(2000);
        check("rand_m0_all_served", done_cnt[0] - d0, issued[0] - i0);
        check("rand_m1_all_served", done_cnt[1] - d1, issued[1] - i1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
